gnss_epoch_arbiter: RTL



---
 rtl/common_types_pkg.sv | 16 +
 rtl/gnss_epoch_arbiter_if.sv | 47 ++++
 rtl/rr_priority_encoder.sv | 38 +++
 rtl/gnss_epoch_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/common_types_pkg.sv
// Shared GNSS arbiter types and constants.
// Channel sizing is reused by the satellite.
package common_types_pkg;

  localparam int GNSS_NCH = 32;
  localparam int GNSS_IDW = $clog2(GNSS_NCH);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ASSERT,
    CLEAR,
    HOLD
  } arb_state_t;

endpackage

// File: rtl/gnss_epoch_arbiter_if.sv
// Epoch flag / interrupt bundle between the
// satellite, the CPU and the arbiter.
interface gnss_epoch_arbiter_if
  import common_types_pkg::*;
#(
  parameter int NCH = GNSS_NCH,
  parameter int IDW = GNSS_IDW
);

  logic [NCH-1:0] epoch_pend;
  logic [NCH-1:0] chan_en;
  logic           arb_en;
  logic           irq_ack;
  logic           overrun_clr;
  logic           irq;
  logic [IDW-1:0] irq_id;
  logic [NCH-1:0] epoch_clr;
  logic           overrun;
  logic           busy;

  modport master (
    output epoch_pend,
    output chan_en,
    output arb_en,
    output irq_ack,
    output overrun_clr,
    input  irq,
    input  irq_id,
    input  epoch_clr,
    input  overrun,
    input  busy
  );

  modport slave (
    input  epoch_pend,
    input  chan_en,
    input  arb_en,
    input  irq_ack,
    input  overrun_clr,
    output irq,
    output irq_id,
    output epoch_clr,
    output overrun,
    output busy
  );

endinterface

// File: rtl/rr_priority_encoder.sv
// Round-robin find-first-set starting one
// past the last serviced channel.
module rr_priority_encoder #(
  parameter int NCH = 32,
  parameter int IDW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] last_id,
  output logic [IDW-1:0] grant,
  output logic           valid
);

  localparam int IW = IDW + 1;
  localparam logic [IW-1:0] NW = IW'(NCH);
  localparam logic [IDW-1:0] LAST = IDW'(NCH - 1);

  logic [IDW-1:0] base;
  logic [IW-1:0]  idx;

  // scan downward so the lowest rotated hit wins
  always_comb begin
    base  = (last_id == LAST) ? '0 : last_id + 1'b1;
    idx   = '0;
    grant = '0;
    valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = {1'b0, base} + IW'(i);
      if (idx >= NW) begin
        idx = idx - NW;
      end
      if (req[idx[IDW-1:0]]) begin
        grant = idx[IDW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gnss_epoch_arbiter.sv
// Round-robin GNSS epoch interrupt sequencer
// with ack timeout and hold-off gap.
module gnss_epoch_arbiter
  import common_types_pkg::*;
#(
  parameter int NCH     = GNSS_NCH,
  parameter int IDW     = $clog2(NCH),
  parameter int HOLDOFF = 4,
  parameter int ACK_TO  = 1024
) (
  input logic clk,
  input logic nrst,
  gnss_epoch_arbiter_if.slave bus
);

  localparam int TW =
    (ACK_TO > 2) ? $clog2(ACK_TO) : 1;
  localparam int HW =
    (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'(ACK_TO - 1);
  localparam logic [HW-1:0] HLAST =
    HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam arb_state_t POST =
    (HOLDOFF == 0) ? IDLE : HOLD;
  localparam logic [NCH-1:0] ONE = NCH'(1);
  localparam logic [IDW-1:0] LAST = IDW'(NCH - 1);
  localparam logic POST_BUSY = (HOLDOFF != 0);

  arb_state_t     state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] last_id;
  logic [IDW-1:0] pe_grant;
  logic           pe_valid;
  logic [TW-1:0]  tcnt;
  logic [HW-1:0]  hcnt;
  logic [NCH-1:0] req;

  assign req = bus.epoch_pend & bus.chan_en;

  rr_priority_encoder #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_pe (
    .req     (req),
    .last_id (last_id),
    .grant   (pe_grant),
    .valid   (pe_valid)
  );

  // arbitration sequence with registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= IDLE;
      grant         <= '0;
      last_id       <= LAST;
      tcnt          <= '0;
      hcnt          <= '0;
      bus.irq       <= 1'b0;
      bus.irq_id    <= '0;
      bus.epoch_clr <= '0;
      bus.overrun   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.epoch_clr <= '0;
      if (bus.overrun_clr) begin
        bus.overrun <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (bus.arb_en && |req) begin
            state    <= SELECT;
            bus.busy <= 1'b1;
          end
        end
        SELECT: begin
          if (pe_valid) begin
            grant      <= pe_grant;
            bus.irq_id <= pe_grant;
            bus.irq    <= 1'b1;
            tcnt       <= '0;
            state      <= ASSERT;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        ASSERT: begin
          if (bus.irq_ack) begin
            bus.irq <= 1'b0;
            state   <= CLEAR;
          end else if (!bus.arb_en ||
                       !bus.epoch_pend[grant]) begin
            bus.irq  <= 1'b0;
            state    <= POST;
            bus.busy <= POST_BUSY;
          end else if (tcnt == TLAST) begin
            bus.irq     <= 1'b0;
            bus.overrun <= 1'b1;
            last_id     <= grant;
            state       <= POST;
            bus.busy    <= POST_BUSY;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        CLEAR: begin
          bus.epoch_clr <= ONE << grant;
          last_id       <= grant;
          state         <= POST;
          bus.busy      <= POST_BUSY;
        end
        HOLD: begin
          if (hcnt == HLAST) begin
            hcnt     <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
